// File: rtl/vga_sync_receiver.sv
// rtl/vga_sync_receiver.sv - VGA sink: rebuilds pixel coordinates, measures line/frame timing, detects lock
module vga_sync_receiver #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter bit SYNC_POL    = 1'b0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pix_en,
  input  logic        i_VGA_HS,
  input  logic        i_VGA_VS,
  input  logic        i_VGA_BLANK_N,
  input  logic [7:0]  i_VGA_R,
  input  logic [7:0]  i_VGA_G,
  input  logic [7:0]  i_VGA_B,
  output logic        o_pix_valid,
  output logic [10:0] o_x,
  output logic [10:0] o_y,
  output logic [7:0]  o_R,
  output logic [7:0]  o_G,
  output logic [7:0]  o_B,
  output logic        o_sof,
  output logic        o_locked,
  output logic [11:0] o_h_total,
  output logic [11:0] o_v_total,
  output logic        o_err
);

  localparam logic [11:0] H_ACT_W = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT_W = 12'(V_ACTIVE);
  localparam logic [11:0] H_TOT_W = 12'(H_TOTAL);
  localparam logic [11:0] V_TOT_W = 12'(V_TOTAL);
  localparam logic [3:0]  LOCK_W  = 4'(LOCK_FRAMES);
  localparam logic [11:0] SAT     = 12'hFFF;

  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

  state_t      state, state_nx;
  logic [3:0]  good_cnt, good_nx;
  logic        err_nx;

  logic        hs_s, hs_d, vs_s, vs_d, bl_s, bl_d;
  logic [7:0]  r_s, g_s, b_s;
  logic [11:0] h_cnt, line_cnt, x_cnt, y_cnt;
  logic        ovr_flag;

  logic        hs_lead, vs_lead, bl_rise, bl_fall;
  logic [11:0] h_meas, h_total_nx, line_meas, x_nx, y_nx;
  logic        overrun, h_bad, frame_ok;

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == SAT) ? v : v + 12'd1;
  endfunction

  // Stage 2 works on the held stage-1 sample against the one before it
  always_comb begin
    hs_lead    = (hs_s == SYNC_POL) && (hs_d != SYNC_POL);
    vs_lead    = (vs_s == SYNC_POL) && (vs_d != SYNC_POL);
    bl_rise    = bl_s && !bl_d;
    bl_fall    = !bl_s && bl_d;
    h_meas     = sat_inc(h_cnt);
    h_total_nx = hs_lead ? h_meas : o_h_total;
    line_meas  = hs_lead ? sat_inc(line_cnt) : line_cnt;
    x_nx       = bl_rise ? 12'd0 : (bl_s ? sat_inc(x_cnt) : x_cnt);
    y_nx       = vs_lead ? 12'd0 : (bl_fall ? sat_inc(y_cnt) : y_cnt);
    overrun    = bl_s && ((x_nx >= H_ACT_W) || (y_nx >= V_ACT_W));
    h_bad      = (h_total_nx != H_TOT_W) || (h_total_nx == SAT);
    frame_ok   = !h_bad && (line_meas == V_TOT_W) && (line_meas != SAT) &&
                 (y_cnt == V_ACT_W) && !ovr_flag && !overrun;
  end

  always_comb begin
    state_nx = state;
    good_nx  = good_cnt;
    err_nx   = o_err;
    case (state)
      SEARCH: begin
        if (vs_lead) begin
          state_nx = ALIGN;
          good_nx  = 4'd0;
        end
      end
      ALIGN: begin
        if (vs_lead) begin
          if (frame_ok) begin
            good_nx = good_cnt + 4'd1;
            if (good_cnt + 4'd1 == LOCK_W) state_nx = LOCKED;
          end else begin
            good_nx = 4'd0;
          end
        end
      end
      LOCKED: begin
        if ((hs_lead && h_bad) || overrun || (vs_lead && !frame_ok)) begin
          err_nx   = 1'b1;
          state_nx = SEARCH;
        end
      end
      default: state_nx = SEARCH;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      hs_s        <= ~SYNC_POL;
      hs_d        <= ~SYNC_POL;
      vs_s        <= ~SYNC_POL;
      vs_d        <= ~SYNC_POL;
      bl_s        <= 1'b0;
      bl_d        <= 1'b0;
      r_s         <= 8'd0;
      g_s         <= 8'd0;
      b_s         <= 8'd0;
      h_cnt       <= 12'd0;
      line_cnt    <= 12'd0;
      x_cnt       <= 12'd0;
      y_cnt       <= 12'd0;
      ovr_flag    <= 1'b0;
      state       <= SEARCH;
      good_cnt    <= 4'd0;
      o_err       <= 1'b0;
      o_h_total   <= 12'd0;
      o_v_total   <= 12'd0;
      o_pix_valid <= 1'b0;
      o_sof       <= 1'b0;
      o_x         <= 11'd0;
      o_y         <= 11'd0;
      o_R         <= 8'd0;
      o_G         <= 8'd0;
      o_B         <= 8'd0;
    end else if (i_pix_en) begin
      hs_s     <= i_VGA_HS;
      hs_d     <= hs_s;
      vs_s     <= i_VGA_VS;
      vs_d     <= vs_s;
      bl_s     <= i_VGA_BLANK_N;
      bl_d     <= bl_s;
      r_s      <= i_VGA_R;
      g_s      <= i_VGA_G;
      b_s      <= i_VGA_B;
      h_cnt    <= hs_lead ? 12'd0 : h_meas;
      line_cnt <= vs_lead ? 12'd0 : line_meas;
      x_cnt    <= x_nx;
      y_cnt    <= y_nx;
      ovr_flag <= vs_lead ? 1'b0 : (ovr_flag | overrun);
      if (hs_lead) o_h_total <= h_meas;
      if (vs_lead) o_v_total <= line_meas;
      state    <= state_nx;
      good_cnt <= good_nx;
      o_err    <= err_nx;
      // Validity follows the state the pixel arrived in, so an overrunning pixel is still reported
      o_pix_valid <= (state == LOCKED) && bl_s;
      o_sof       <= (state == LOCKED) && bl_s && (x_nx == 12'd0) && (y_nx == 12'd0);
      o_x         <= x_nx[10:0];
      o_y         <= y_nx[10:0];
      o_R         <= r_s;
      o_G         <= g_s;
      o_B         <= b_s;
    end
  end

  assign o_locked = (state == LOCKED);

endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb/tb_vga_sync_receiver.sv - self-checking bench for vga_sync_receiver in a reduced 24x10 timing mode
module tb_vga_sync_receiver;
  localparam int H_ACT = 16, H_TOT = 24, HS_START = 18, H_SYNC = 4;
  localparam int V_ACT = 6, V_TOT = 10, VS_START = 7;
  localparam int LOCKF = 2;

  logic        i_clk = 1'b0, i_rst_n = 1'b0, i_pix_en = 1'b0;
  logic        i_VGA_HS = 1'b1, i_VGA_VS = 1'b1, i_VGA_BLANK_N = 1'b0;
  logic [7:0]  i_VGA_R = 8'd0, i_VGA_G = 8'd0, i_VGA_B = 8'd0;
  logic        o_pix_valid, o_sof, o_locked, o_err;
  logic [10:0] o_x, o_y;
  logic [7:0]  o_R, o_G, o_B;
  logic [11:0] o_h_total, o_v_total;

  always #5 i_clk = ~i_clk;

  vga_sync_receiver #(
    .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .H_TOTAL(H_TOT), .V_TOTAL(V_TOT),
    .SYNC_POL(1'b0), .LOCK_FRAMES(LOCKF)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pix_en(i_pix_en),
    .i_VGA_HS(i_VGA_HS), .i_VGA_VS(i_VGA_VS), .i_VGA_BLANK_N(i_VGA_BLANK_N),
    .i_VGA_R(i_VGA_R), .i_VGA_G(i_VGA_G), .i_VGA_B(i_VGA_B),
    .o_pix_valid(o_pix_valid), .o_x(o_x), .o_y(o_y),
    .o_R(o_R), .o_G(o_G), .o_B(o_B), .o_sof(o_sof), .o_locked(o_locked),
    .o_h_total(o_h_total), .o_v_total(o_v_total), .o_err(o_err)
  );

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        sof;
  } pix_t;

  typedef struct {
    bit tog;
    int long_ln;
    int wide_ln;
    bit e_lock;
    bit e_err;
    int e_h;
    int e_v;
  } row_t;

  int tests = 0, fails = 0;
  pix_t q[$];
  pix_t exp_p;

  // Reference model state: 0 search, 1 align, 2 locked
  int m_st, m_good, m_since, m_hlen, m_lines, m_x, m_y;
  bit m_err, m_ovr, m_hs_p, m_vs_p, m_bl_p;

  logic [73:0] out_vec, snap = '0;
  logic mon_en, mon_rn;
  assign out_vec = {o_pix_valid, o_x, o_y, o_R, o_G, o_B, o_sof, o_locked,
                    o_h_total, o_v_total, o_err};

  task automatic check(input string name, input logic [73:0] act, input logic [73:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_good = 0; m_since = 0; m_hlen = 0; m_lines = 0; m_x = 0; m_y = 0;
    m_err = 0; m_ovr = 0; m_hs_p = 1; m_vs_p = 1; m_bl_p = 0;
    q.delete();
  endtask

  task automatic model_step(input logic hs, input logic vs, input logic bl,
                            input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                            input int h, input int v);
    bit hs_l, vs_l, bl_r, bl_f, ovr, ok, bad;
    int y_pre, vlen;
    pix_t p;
    hs_l = !hs && m_hs_p;
    vs_l = !vs && m_vs_p;
    bl_r = bl && !m_bl_p;
    bl_f = !bl && m_bl_p;
    m_hs_p = hs; m_vs_p = vs; m_bl_p = bl;
    if (m_st == 2 && bl) begin
      p.x = 11'(h); p.y = 11'(v); p.r = r; p.g = g; p.b = b;
      p.sof = (h == 0 && v == 0);
      q.push_back(p);
    end
    y_pre = m_y;
    if (bl) m_x = bl_r ? 0 : m_x + 1;
    if (vs_l) m_y = 0;
    else if (bl_f) m_y = m_y + 1;
    ovr = bl && (m_x >= H_ACT || m_y >= V_ACT);
    if (hs_l) begin
      m_hlen = m_since + 1; m_since = 0; m_lines = m_lines + 1;
    end else begin
      m_since = m_since + 1;
    end
    vlen = m_lines;
    if (vs_l) m_lines = 0;
    ok  = (m_hlen == H_TOT) && (vlen == V_TOT) && (y_pre == V_ACT) && !m_ovr && !ovr;
    bad = ovr || (hs_l && m_hlen != H_TOT) || (vs_l && !ok);
    if (m_st == 2) begin
      if (bad) begin m_err = 1; m_st = 0; end
    end else if (vs_l) begin
      if (m_st == 0) begin
        m_st = 1; m_good = 0;
      end else if (ok) begin
        m_good = m_good + 1;
        if (m_good == LOCKF) m_st = 2;
      end else begin
        m_good = 0;
      end
    end
    m_ovr = vs_l ? 1'b0 : (m_ovr | ovr);
  endtask

  task automatic drive(input bit tog, input logic hs, input logic vs, input logic bl,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input int h, input int v);
    if (tog) begin
      @(negedge i_clk);
      i_pix_en = 0;
      i_VGA_HS = 1'($urandom_range(0, 1));
      i_VGA_VS = 1'($urandom_range(0, 1));
      i_VGA_BLANK_N = 1'($urandom_range(0, 1));
      i_VGA_R = 8'($urandom); i_VGA_G = 8'($urandom); i_VGA_B = 8'($urandom);
    end
    @(negedge i_clk);
    i_pix_en = 1;
    i_VGA_HS = hs; i_VGA_VS = vs; i_VGA_BLANK_N = bl;
    i_VGA_R = r; i_VGA_G = g; i_VGA_B = b;
    model_step(hs, vs, bl, r, g, b, h, v);
  endtask

  task automatic run_frame(input bit tog, input int long_ln, input int wide_ln, input int n_lines);
    logic hs, vs, bl;
    logic [7:0] r, g, b;
    int len;
    for (int v = 0; v < n_lines; v++) begin
      len = H_TOT + ((v == long_ln) ? 1 : 0);
      for (int h = 0; h < len; h++) begin
        hs = !((h >= HS_START) && (h < HS_START + H_SYNC));
        vs = !(((v == VS_START) && (h >= HS_START)) || (v == VS_START + 1) ||
               ((v == VS_START + 2) && (h < HS_START)));
        bl = (v < V_ACT) && (h < H_ACT + ((v == wide_ln) ? 1 : 0));
        if (h == H_ACT - 1 && v == V_ACT - 1) begin
          r = 8'd255; g = 8'd0; b = 8'd128;
        end else begin
          r = 8'(h * 13 + v); g = 8'(v * 37 + h); b = 8'(h ^ (v << 4));
        end
        drive(tog, hs, vs, bl, r, g, b, h, v);
      end
    end
  endtask

  task automatic do_reset(input string name);
    @(negedge i_clk);
    i_rst_n = 0; i_pix_en = 0;
    i_VGA_HS = 1; i_VGA_VS = 1; i_VGA_BLANK_N = 0;
    @(posedge i_clk);
    #1;
    check({name, "_outputs"}, out_vec, 74'd0);
    check({name, "_locked"}, 74'(o_locked), 74'd0);
    check({name, "_err"}, 74'(o_err), 74'd0);
    @(negedge i_clk);
    i_rst_n = 1;
    model_reset();
  endtask

  // Scoreboard pop on every processing strobe; outputs must hold between strobes
  always @(posedge i_clk) begin
    mon_en = i_pix_en;
    mon_rn = i_rst_n;
    #1;
    if (!mon_rn) begin
      snap = out_vec;
    end else if (mon_en) begin
      if (o_pix_valid) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL pix_unexpected: got valid x=%0d y=%0d, required no valid pixel", o_x, o_y);
        end else begin
          exp_p = q.pop_front();
          check("pixel", 74'({o_x, o_y, o_R, o_G, o_B, o_sof}), 74'(exp_p));
        end
      end
      snap = out_vec;
    end else begin
      check("hold", out_vec, snap);
    end
  end

  initial begin
    row_t rows[14];
    rows[0]  = '{0, -1, -1, 0, 0, 24, 8};
    rows[1]  = '{0, -1, -1, 0, 0, 24, 10};
    rows[2]  = '{0, -1, -1, 1, 0, 24, 10};
    rows[3]  = '{0, -1, -1, 1, 0, 24, 10};
    rows[4]  = '{0,  2, -1, 0, 1, 24, 10};
    rows[5]  = '{0, -1, -1, 0, 1, 24, 10};
    rows[6]  = '{0, -1, -1, 1, 1, 24, 10};
    rows[7]  = '{1, -1, -1, 0, 0, 24, 8};
    rows[8]  = '{1, -1, -1, 0, 0, 24, 10};
    rows[9]  = '{1, -1, -1, 1, 0, 24, 10};
    rows[10] = '{1, -1, -1, 1, 0, 24, 10};
    rows[11] = '{0, -1,  1, 0, 1, 24, 10};
    rows[12] = '{0, -1, -1, 0, 1, 24, 10};
    rows[13] = '{0, -1, -1, 1, 1, 24, 10};

    model_reset();
    do_reset("rst_init");
    for (int i = 0; i < 14; i++) begin
      if (i == 7) begin
        run_frame(1'b0, -1, -1, 4);
        do_reset("rst_mid");
      end
      run_frame(rows[i].tog, rows[i].long_ln, rows[i].wide_ln, V_TOT);
      check($sformatf("row%0d_locked", i), 74'(o_locked), 74'(rows[i].e_lock));
      check($sformatf("row%0d_err", i), 74'(o_err), 74'(rows[i].e_err));
      check($sformatf("row%0d_h_total", i), 74'(o_h_total), 74'(rows[i].e_h));
      check($sformatf("row%0d_v_total", i), 74'(o_v_total), 74'(rows[i].e_v));
    end
    check("pixels_outstanding", 74'(q.size()), 74'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
